// File: rtl/car_warning_pkg.sv
// ---------------------------------------------------------------------------
// car_warning_pkg
// Shared definitions for the car warning controller:
//   state_e  - warning FSM states (IDLE, GRACE, CHIME, MUTED)
//   DEB_CYC  - cycles an input must hold a level before the debounce filter
//              accepts it (used only when CAR_WARN_DEBOUNCE_EN is defined)
//   max2     - elaboration-time helper for sizing the shared timer
// ---------------------------------------------------------------------------
package car_warning_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRACE = 2'd1,
    CHIME = 2'd2,
    MUTED = 2'd3
  } state_e;

  localparam int DEB_CYC = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/car_warning_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// warn_debounce
// Per-bit 2-flop synchroniser followed by a stable-level filter: a bit's
// output only follows the synchronised input after it has differed from the
// current output for DEB_CYC consecutive cycles (6 cycles total latency).
// Instantiated by car_warning_ctrl only when CAR_WARN_DEBOUNCE_EN is defined.
// Ports:
//   clk   in       system clock
//   rst   in       asynchronous active-high reset
//   i_d   in  [W]  raw switch inputs
//   o_q   out [W]  synchronised, filtered levels
// ---------------------------------------------------------------------------
module warn_debounce
  import car_warning_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [W-1:0]  r_s1;
  logic [W-1:0]  r_s2;
  logic [W-1:0]  r_q;
  logic [DW-1:0] r_cnt [W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_q  <= '0;
      for (int i = 0; i < W; i++) r_cnt[i] <= DW'(DEB_CYC - 1);
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      for (int i = 0; i < W; i++) begin
        // down-counter reloads whenever the level agrees with the output
        if (r_s2[i] == r_q[i]) begin
          r_cnt[i] <= DW'(DEB_CYC - 1);
        end else if (r_cnt[i] == '0) begin
          r_q[i]   <= r_s2[i];
          r_cnt[i] <= DW'(DEB_CYC - 1);
        end else begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/car_warning_ctrl.sv
// ---------------------------------------------------------------------------
// car_warning_ctrl
// Door / seat-belt warning controller. A violation (ignition on and any door
// open or any occupied seat unbelted) lights the lamp at once, starts an
// audible chime after a grace period, mutes the chime after CHIME_MAX cycles
// and re-arms if a new violation source appears while muted.
//
// state | meaning
// IDLE  | no violation, lamp and chime off
// GRACE | violation present, lamp on, waiting GRACE_CYC cycles
// CHIME | lamp on, chime square wave with CHIME_HALF half-period
// MUTED | lamp on, chime silenced until violation clears or a new source
//
// Ports:
//   clk           in            system clock
//   rst           in            asynchronous active-high reset
//   i_ignition    in            ignition on
//   i_door_close  in  [N_DOORS] 1 = door closed
//   i_seat_belt   in  [N_SEATS] 1 = belt fastened
//   i_seat_occ    in  [N_SEATS] 1 = seat occupied (seat 0 forced occupied)
//   o_alarm       out           warning lamp (registered)
//   o_chime       out           chime square wave (registered)
//   o_seat_warn   out [N_SEATS] per-seat unbelted flag (registered)
//   o_door_warn   out [N_DOORS] per-door open flag (registered)
//
// Build option: define CAR_WARN_DEBOUNCE_EN to route door/belt/occupancy
// inputs through warn_debounce; otherwise they are used as sampled.
// ---------------------------------------------------------------------------
module car_warning_ctrl
  import car_warning_pkg::*;
#(
  parameter int N_DOORS    = 4,
  parameter int N_SEATS    = 2,
  parameter int GRACE_CYC  = 1000,
  parameter int CHIME_HALF = 250,
  parameter int CHIME_MAX  = 8000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ignition,
  input  logic [N_DOORS-1:0] i_door_close,
  input  logic [N_SEATS-1:0] i_seat_belt,
  input  logic [N_SEATS-1:0] i_seat_occ,
  output logic               o_alarm,
  output logic               o_chime,
  output logic [N_SEATS-1:0] o_seat_warn,
  output logic [N_DOORS-1:0] o_door_warn
);

  localparam int CNT_MAX = max2(GRACE_CYC, CHIME_MAX);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [N_DOORS-1:0] w_door;
  logic [N_SEATS-1:0] w_belt;
  logic [N_SEATS-1:0] w_occ_raw;
  logic [N_SEATS-1:0] w_occ;
  logic [N_SEATS-1:0] w_seat_warn_d;
  logic [N_DOORS-1:0] w_door_warn_d;
  logic               w_viol;
  logic               w_rise;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_alarm_d;
  logic               w_chime_d;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_alarm;
  logic               r_chime;
  logic [N_SEATS-1:0] r_seat_warn;
  logic [N_DOORS-1:0] r_door_warn;

`ifdef CAR_WARN_DEBOUNCE_EN
  warn_debounce #(
    .W (N_DOORS + 2 * N_SEATS)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .i_d ({i_door_close, i_seat_belt, i_seat_occ}),
    .o_q ({w_door, w_belt, w_occ_raw})
  );
`else
  assign w_door    = i_door_close;
  assign w_belt    = i_seat_belt;
  assign w_occ_raw = i_seat_occ;
`endif

  // driver seat counts as occupied regardless of its sensor
  assign w_occ         = w_occ_raw | N_SEATS'(1);
  assign w_seat_warn_d = {N_SEATS{i_ignition}} & w_occ & ~w_belt;
  assign w_door_warn_d = {N_DOORS{i_ignition}} & ~w_door;
  assign w_viol        = (|w_seat_warn_d) | (|w_door_warn_d);
  // a source that was quiet last cycle and is flagged now
  assign w_rise        = |({w_seat_warn_d, w_door_warn_d} & ~{r_seat_warn, r_door_warn});

  // state register (plus timer and registered outputs)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_alarm     <= 1'b0;
      r_chime     <= 1'b0;
      r_seat_warn <= '0;
      r_door_warn <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_alarm     <= w_alarm_d;
      r_chime     <= w_chime_d;
      r_seat_warn <= w_seat_warn_d;
      r_door_warn <= w_door_warn_d;
    end
  end

  // next-state logic; ignition off (or no violation) wins over everything
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    if (!i_ignition || !w_viol) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = GRACE;
          w_cnt_nxt   = '0;
        end
        GRACE: begin
          if (r_cnt == CNT_W'(GRACE_CYC - 1)) begin
            w_state_nxt = CHIME;
            w_cnt_nxt   = '0;
          end
        end
        CHIME: begin
          if (r_cnt == CNT_W'(CHIME_MAX - 1)) begin
            w_state_nxt = MUTED;
            w_cnt_nxt   = '0;
          end
        end
        MUTED: begin
          w_cnt_nxt = '0;
          if (w_rise) w_state_nxt = GRACE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // outputs decoded from the upcoming state so they change on the same edge
  always_comb begin
    w_alarm_d = (w_state_nxt != IDLE);
    w_chime_d = (w_state_nxt == CHIME) &&
                ((int'(w_cnt_nxt) % (2 * CHIME_HALF)) < CHIME_HALF);
  end

  assign o_alarm     = r_alarm;
  assign o_chime     = r_chime;
  assign o_seat_warn = r_seat_warn;
  assign o_door_warn = r_door_warn;

endmodule

// File: tb/tb_car_warning_ctrl.sv
module tb_car_warning_ctrl;

  localparam int ND = 2;
  localparam int NS = 2;
  localparam int G  = 4;
  localparam int H  = 2;
  localparam int M  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ign = 1'b0;
  logic [ND-1:0] door = 2'b11;
  logic [NS-1:0] belt = 2'b11;
  logic [NS-1:0] occ  = 2'b11;
  logic          alarm;
  logic          chime;
  logic [NS-1:0] seat_warn;
  logic [ND-1:0] door_warn;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  car_warning_ctrl #(
    .N_DOORS    (ND),
    .N_SEATS    (NS),
    .GRACE_CYC  (G),
    .CHIME_HALF (H),
    .CHIME_MAX  (M)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_ignition   (ign),
    .i_door_close (door),
    .i_seat_belt  (belt),
    .i_seat_occ   (occ),
    .o_alarm      (alarm),
    .o_chime      (chime),
    .o_seat_warn  (seat_warn),
    .o_door_warn  (door_warn)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a violation timeline. m_t counts cycles since the lamp
  // was (re-)armed; grace, chime and mute are windows on that timeline.
  bit            m_armed = 1'b0;
  int            m_t = 0;
  logic [NS-1:0] m_sw = '0;
  logic [ND-1:0] m_dw = '0;
  logic [NS-1:0] n_sw;
  logic [ND-1:0] n_dw;
  bit            m_chime;

  always @(posedge clk) begin
    if (rst) begin
      m_armed = 1'b0;
      m_t     = 0;
      m_sw    = '0;
      m_dw    = '0;
    end else begin
      n_sw = ign ? ((occ | 2'b01) & ~belt) : 2'b00;
      n_dw = ign ? ~door : 2'b00;
      if (n_sw == 0 && n_dw == 0) begin
        m_armed = 1'b0;
        m_t     = 0;
      end else if (!m_armed) begin
        m_armed = 1'b1;
        m_t     = 0;
      end else if (m_t >= G + M && (({n_sw, n_dw} & ~{m_sw, m_dw}) != 0)) begin
        m_t = 0;
      end else if (m_t < G + M) begin
        m_t++;
      end
      m_sw = n_sw;
      m_dw = n_dw;
    end
    m_chime = m_armed && (m_t >= G) && (m_t < G + M) && ((((m_t - G) / H) % 2) == 0);
    #1;
    check("alarm", alarm, m_armed);
    check("chime", chime, m_chime);
    check("seat_warn", seat_warn, m_sw);
    check("door_warn", door_warn, m_dw);
  end

  initial begin
    int r;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // all closed, all belted: quiet
    ign = 1'b1; door = 2'b11; belt = 2'b11; occ = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("quiet_alarm", alarm, 1'b0);
      check("quiet_chime", chime, 1'b0);
    end

    // driver unbelted: grace, chime 1100..., mute
    belt = 2'b10;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("lit_alarm_on", alarm, 1'b1);
        check("lit_seat_warn", seat_warn, 2'b01);
      end
      if (k == 4)  check("lit_grace_end", chime, 1'b0);
      if (k == 5)  check("lit_chime_rise", chime, 1'b1);
      if (k == 6)  check("lit_chime_hi2", chime, 1'b1);
      if (k == 7)  check("lit_chime_lo", chime, 1'b0);
      if (k == 9)  check("lit_chime_hi3", chime, 1'b1);
      if (k == 20) check("lit_chime_last", chime, 1'b0);
      if (k == 21) begin
        check("lit_muted_chime", chime, 1'b0);
        check("lit_muted_alarm", alarm, 1'b1);
      end
    end

    // new door opens while muted: re-arm
    door = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("lit_rearm_dw", door_warn, 2'b10);
        check("lit_rearm_alarm", alarm, 1'b1);
      end
      if (k == 4) check("lit_rearm_grace", chime, 1'b0);
      if (k == 5) check("lit_rearm_chime", chime, 1'b1);
    end

    // ignition off mid-chime
    ign = 1'b0;
    @(negedge clk);
    check("lit_ign_alarm", alarm, 1'b0);
    check("lit_ign_chime", chime, 1'b0);
    check("lit_ign_dw", door_warn, 2'b00);

    // unoccupied passenger ignored, driver still flagged
    ign = 1'b1; door = 2'b11; belt = 2'b00; occ = 2'b00;
    @(negedge clk);
    check("lit_occ_sw", seat_warn, 2'b01);
    check("lit_occ_alarm", alarm, 1'b1);

    // async reset mid-grace, no clock edge in between
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("lit_rst_alarm", alarm, 1'b0);
    check("lit_rst_sw", seat_warn, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      r = $urandom_range(0, 63);
      if (!ign) begin
        if (r < 8) ign = 1'b1;
      end else if (r == 0) begin
        ign = 1'b0;
      end else if (r == 1) begin
        door = 2'($urandom);
      end else if (r == 2) begin
        belt = 2'($urandom);
      end else if (r == 3) begin
        occ = 2'($urandom);
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/car_warning_ctrl.md
CAR_WARNING_CTRL -- requirements
Module: car_warning_ctrl

Interface
REQ-001 Parameter N_DOORS, default 4: number of door-closed switches.
REQ-002 Parameter N_SEATS, default 2: number of seat channels (belt and occupancy).
REQ-003 Parameter GRACE_CYC, default 1000: cycles a violation persists before the chime starts.
REQ-004 Parameter CHIME_HALF, default 250: chime half-period in cycles.
REQ-005 Parameter CHIME_MAX, default 8000: cycles of chiming before auto-mute.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 Ignition  input  1  ignition on.
REQ-009 DoorClose  input  N_DOORS  1 = door closed, one bit per door.
REQ-010 SeatBelt  input  N_SEATS  1 = belt fastened, one bit per seat.
REQ-011 SeatOcc  input  N_SEATS  1 = seat occupied; seat 0 (driver) is always treated as occupied.
REQ-012 Alarm  output  1  warning lamp, registered.
REQ-013 Chime  output  1  audible square wave, registered.
REQ-014 SeatWarn  output  N_SEATS  per-seat unbelted indication, registered.
REQ-015 DoorWarn  output  N_DOORS  per-door open indication, registered.

Function
REQ-016 Violation v = Ignition & (any DoorClose bit 0 | any seat with occupied & ~SeatBelt), evaluated on the synchronised/filtered inputs.
REQ-017 SeatWarn[i] = Ignition & occ[i] & ~SeatBelt[i], and DoorWarn[j] = Ignition & ~DoorClose[j], both registered with 1-cycle latency.
REQ-018 FSM states: IDLE, GRACE, CHIME, MUTED; a single down/up counter sized $clog2 of the largest of GRACE_CYC, CHIME_MAX.
REQ-019 IDLE: Alarm=0, Chime=0; v=1 -> GRACE with the counter cleared.
REQ-020 GRACE: Alarm=1, Chime=0; v=0 -> IDLE; counter reaching GRACE_CYC-1 with v=1 -> CHIME.
REQ-021 CHIME: Alarm=1; Chime starts at 1 and toggles every CHIME_HALF cycles; after CHIME_MAX cycles -> MUTED; v=0 -> IDLE.
REQ-022 MUTED: Alarm=1, Chime=0; v=0 -> IDLE; a new violation source appearing (rising bit in {SeatWarn,DoorWarn}) -> GRACE (re-arm).
REQ-023 Ignition=0 forces IDLE from any state on the next edge; it takes priority over every other transition.
REQ-024 Alarm/Chime transitions occur on the edge of the state change (1-cycle latency from v).

Reset
REQ-025 While rst=1, state=IDLE, counter=0, and every output is 0; after deassertion the first evaluation occurs on the next rising clk.
REQ-026 Reset mid-CHIME clears Chime immediately (asynchronously) without waiting for a clock.

Configuration
REQ-027 Macro CAR_WARN_DEBOUNCE_EN: when defined, each DoorClose/SeatBelt/SeatOcc bit passes through a 2-flop synchroniser plus a 4-cycle stable-level filter before use (+6 cycles latency); when undefined, inputs are used directly as sampled.

Structure
REQ-028 Package car_warning_pkg holds the state enum (IDLE, GRACE, CHIME, MUTED) and the debounce length constant DEB_CYC=4.
REQ-029 Sub-module warn_debounce (1-bit, parameterised width-replicated) implements REQ-027 and is instantiated only under the macro.

Verification (N_DOORS=2, N_SEATS=2, GRACE_CYC=4, CHIME_HALF=2, CHIME_MAX=16, macro off)
REQ-030 Ignition=1, doors=2'b11, belts=2'b11 -> Alarm=0, Chime=0 indefinitely.
REQ-031 Ignition=1, SeatBelt=2'b10 -> Alarm=1 next cycle, Chime rises 4 cycles later, toggles 1100 pattern, goes to 0 after 16 cycles (MUTED), Alarm stays 1.
REQ-032 In MUTED, DoorClose 2'b11->2'b01 -> DoorWarn=2'b10, GRACE, chime resumes after 4 cycles.
REQ-033 SeatOcc=2'b00, SeatBelt=2'b10 -> seat 1 ignored, driver still flags: SeatWarn=2'b01, Alarm=1.
REQ-034 Mid-CHIME Ignition->0 -> all outputs 0 next edge; rst pulse mid-GRACE -> outputs 0 without a clock edge.
